// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizes for the bit-serial sequence scan controller.
package seq_ctrl_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PAT_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int STATE_WIDTH = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        SHIFT = 4'd2,
        DONE  = 4'd3
    } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word stream into the scan controller: valid/ready handshake plus end-of-run marker.
interface seq_scan_ctrl_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_last, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_last, input  in_valid, output in_ready);

endinterface

// File: rtl/seq_prog_det.sv
// Programmable serial pattern matcher: history shift register, fill counter,
// length-masked compare and a registered one-cycle match pulse.
module seq_prog_det #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] hist_r;
    logic [LEN_W-1:0] fill_r;
    logic [PAT_W-1:0] hist_nxt_s;
    logic [LEN_W-1:0] fill_nxt_s;
    logic [PAT_W-1:0] mask_s;
    logic             hit_s;

    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (LEN_W'(i) < l);
        end
        return m;
    endfunction

    // Next history/fill and hit decision for the bit currently on the line
    always_comb begin
        hist_nxt_s = {hist_r[PAT_W-2:0], bit_in};
        if (fill_r == LEN_W'(PAT_W)) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + LEN_W'(1);
        end
        mask_s = len_mask(len);
        hit_s  = (fill_nxt_s >= len) && ((hist_nxt_s & mask_s) == (pattern & mask_s));
    end

    // History, fill and match registers; non-overlap mode restarts the fill on a hit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_r <= '0;
            fill_r <= '0;
            match  <= 1'b0;
        end else if (clr) begin
            hist_r <= '0;
            fill_r <= '0;
            match  <= 1'b0;
        end else if (bit_valid) begin
            hist_r <= hist_nxt_s;
            fill_r <= (hit_s && !overlap) ? '0 : fill_nxt_s;
            match  <= hit_s;
        end else begin
            match  <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Run controller: config shadow, start/busy/done FSM, MSB-first word serializer
// and saturating match counter around the programmable pattern matcher.
module seq_scan_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int LEN_W  = $clog2(PAT_W) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 start,
    seq_scan_ctrl_if.slave       stream,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_r;
    logic [DATA_W-1:0] word_r;
    logic              last_r;
    logic [IDX_W-1:0]  idx_r;
    logic [PAT_W-1:0]  pat_r;
    logic [LEN_W-1:0]  len_r;
    logic              ovl_r;
    logic              run_go_s;

    function automatic logic len_legal(input logic [LEN_W-1:0] l);
        return (l != '0) && (l <= LEN_W'(PAT_W));
    endfunction

    assign run_go_s = (state_r == IDLE) && start && len_legal(len_r);

    // Run sequencing FSM with serializer, config shadow and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            word_r          <= '0;
            last_r          <= 1'b0;
            idx_r           <= '0;
            pat_r           <= '0;
            len_r           <= '0;
            ovl_r           <= 1'b0;
            stream.in_ready <= 1'b0;
            bit_out         <= 1'b0;
            bit_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            done <= 1'b0;
            // Config writes are only honoured while idle; a rejected start also flags
            if (state_r != IDLE) begin
                cfg_err <= cfg_we;
            end else begin
                cfg_err <= start && !len_legal(len_r);
            end
            case (state_r)
                IDLE: begin
                    if (cfg_we) begin
                        pat_r <= cfg_pattern;
                        len_r <= cfg_len;
                        ovl_r <= cfg_overlap;
                    end
                    if (run_go_s) begin
                        state_r         <= LOAD;
                        busy            <= 1'b1;
                        stream.in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (stream.in_valid) begin
                        word_r          <= {stream.in_data[DATA_W-2:0], 1'b0};
                        last_r          <= stream.in_last;
                        idx_r           <= '0;
                        bit_out         <= stream.in_data[DATA_W-1];
                        bit_valid       <= 1'b1;
                        stream.in_ready <= 1'b0;
                        state_r         <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx_r == IDX_W'(DATA_W - 1)) begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        if (last_r) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r         <= LOAD;
                            stream.in_ready <= 1'b1;
                        end
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        bit_out <= word_r[DATA_W-1];
                        word_r  <= {word_r[DATA_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r         <= IDLE;
                    busy            <= 1'b0;
                    bit_valid       <= 1'b0;
                    bit_out         <= 1'b0;
                    stream.in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-run match counter, cleared when a run is launched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (run_go_s) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    seq_prog_det #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (run_go_s),
        .bit_in    (bit_out),
        .bit_valid (bit_valid),
        .pattern   (pat_r),
        .len       (len_r),
        .overlap   (ovl_r),
        .match     (match)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl: one task per scenario, inline comparisons.
module tb_seq_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        start;
    logic        bit_out;
    logic        bit_valid;
    logic        match;
    logic [15:0] match_cnt;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    int          mon_bitpos;
    int          mon_matches;
    int          mon_done;
    logic [15:0] mon_mask;

    seq_scan_ctrl_if #(.DATA_W(8)) stream ();

    seq_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .stream      (stream),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive monitor: records the bit index completed by each match and counts done pulses
    always @(negedge clk) begin
        if (match === 1'b1) begin
            mon_matches = mon_matches + 1;
            if (mon_bitpos > 0 && mon_bitpos <= 16) mon_mask[mon_bitpos-1] = 1'b1;
        end
        if (bit_valid === 1'b1) mon_bitpos = mon_bitpos + 1;
        if (done === 1'b1) mon_done = mon_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_bitpos  = 0;
        mon_matches = 0;
        mon_done    = 0;
        mon_mask    = 16'h0000;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] data, input logic last);
        stream.in_data  = data;
        stream.in_last  = last;
        stream.in_valid = 1'b1;
        tick();
        stream.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; start = 1'b0;
        stream.in_data = 8'h00; stream.in_last = 1'b0; stream.in_valid = 1'b0;
        clear_mon();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, stream.in_ready, bit_valid, bit_out, match, done, cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {busy, stream.in_ready, bit_valid, bit_out, match, done, cfg_err});
        end
        checks++;
        if (match_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_match_cnt: got %0d, expected 0", match_cnt);
        end
    endtask

    task automatic test_cfg_len_zero();
        pulse_start();
        checks++;
        if ({cfg_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL len0_start: cfg_err,busy=%b, expected 10", {cfg_err, busy});
        end
        tick();
        checks++;
        if ({cfg_err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL len0_pulse_end: cfg_err,busy=%b, expected 00", {cfg_err, busy});
        end
    endtask

    task automatic test_overlap(input logic ovl, input int exp_cnt, input logic [15:0] exp_mask);
        int n;
        configure(8'h05, 4'd3, ovl);
        clear_mon();
        pulse_start();
        checks++;
        if ({busy, stream.in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL ovl%0d_start_to_load: busy,in_ready=%b, expected 11", ovl, {busy, stream.in_ready});
        end
        send_word(8'hAD, 1'b1);
        checks++;
        if ({bit_valid, bit_out} !== 2'b11) begin
            errors++;
            $display("FAIL ovl%0d_first_bit: bit_valid,bit_out=%b, expected 11", ovl, {bit_valid, bit_out});
        end
        wait_done(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL ovl%0d_done_latency: got %0d cycles, expected 8", ovl, n);
        end
        tick();
        checks++;
        if (mon_mask !== exp_mask) begin
            errors++;
            $display("FAIL ovl%0d_match_bits: got %h, expected %h", ovl, mon_mask, exp_mask);
        end
        checks++;
        if (match_cnt !== 16'(exp_cnt) || mon_matches != exp_cnt) begin
            errors++;
            $display("FAIL ovl%0d_match_cnt: cnt %0d pulses %0d, expected %0d", ovl, match_cnt, mon_matches, exp_cnt);
        end
        checks++;
        if (mon_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovl%0d_done_pulse: done pulses %0d busy %b, expected 1 and 0", ovl, mon_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int   c;
        int   nacc;
        int   acc1;
        int   acc2;
        int   bad;
        logic acc;
        logic got_done;
        configure(8'h03, 4'd2, 1'b1);
        clear_mon();
        pulse_start();
        stream.in_data = 8'h01; stream.in_last = 1'b0; stream.in_valid = 1'b1;
        c = 0; nacc = 0; acc1 = 0; acc2 = 0; bad = 0; got_done = 1'b0;
        while (!got_done && c < 60) begin
            if (bit_valid === 1'b1 && stream.in_ready !== 1'b0) bad++;
            acc = stream.in_valid && stream.in_ready;
            tick();
            c++;
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    acc1 = c;
                    stream.in_data = 8'h80; stream.in_last = 1'b1;
                end else begin
                    acc2 = c;
                    stream.in_valid = 1'b0;
                end
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        stream.in_valid = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL b2b_timeout: no done within %0d cycles, expected done", c);
        end
        checks++;
        if (nacc != 2 || (acc2 - acc1) != 9) begin
            errors++;
            $display("FAIL b2b_throughput: %0d accepts spaced %0d, expected 2 spaced 9", nacc, acc2 - acc1);
        end
        checks++;
        if (bad != 0 || mon_bitpos != 16) begin
            errors++;
            $display("FAIL b2b_ready_in_shift: %0d ready-high bit cycles of %0d, expected 0 of 16", bad, mon_bitpos);
        end
        tick();
        checks++;
        if (mon_mask !== 16'h0100 || match_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_boundary_match: bits %h cnt %0d, expected 0100 and 1", mon_mask, match_cnt);
        end
    endtask

    task automatic test_load_stall();
        logic [7:0] bits;
        configure(8'h05, 4'd3, 1'b1);
        clear_mon();
        pulse_start();
        stream.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bit_valid, stream.in_ready, busy} !== 3'b011) begin
                errors++;
                $display("FAIL stall_cycle%0d: bit_valid,in_ready,busy=%b, expected 011",
                         i, {bit_valid, stream.in_ready, busy});
            end
            tick();
        end
        send_word(8'hAD, 1'b1);
        bits = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bit_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_bit_valid%0d: got %b, expected 1", i, bit_valid);
            end
            bits = {bits[6:0], bit_out};
            tick();
        end
        checks++;
        if (done !== 1'b1 || bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_edge: done,bit_valid=%b, expected 10", {done, bit_valid});
        end
        checks++;
        if (bits !== 8'hAD) begin
            errors++;
            $display("FAIL stall_bits: got %h, expected ad", bits);
        end
        tick();
        checks++;
        if (match_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_match_cnt: got %0d, expected 3", match_cnt);
        end
    endtask

    task automatic test_ignored_inputs();
        int n;
        configure(8'h05, 4'd3, 1'b1);
        clear_mon();
        pulse_start();
        send_word(8'hAD, 1'b1);
        tick();
        cfg_pattern = 8'h07; cfg_len = 4'd3; cfg_overlap = 1'b0; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL busy_cfg_we_err: got %b, expected 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL busy_cfg_err_pulse: got %b, expected 0", cfg_err);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({cfg_err, busy, bit_valid} !== 3'b011) begin
            errors++;
            $display("FAIL busy_start_ignored: cfg_err,busy,bit_valid=%b, expected 011", {cfg_err, busy, bit_valid});
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_run_timeout: done %b after %0d cycles, expected 1", done, n);
        end
        tick();
        checks++;
        if (match_cnt !== 16'd3 || mon_matches != 3) begin
            errors++;
            $display("FAIL busy_pattern_kept: cnt %0d pulses %0d, expected 3", match_cnt, mon_matches);
        end
        tick();
        checks++;
        if ({busy, stream.in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL busy_start_not_queued: busy,in_ready=%b, expected 00", {busy, stream.in_ready});
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        configure(8'h05, 4'd3, 1'b1);
        clear_mon();
        pulse_start();
        send_word(8'hAD, 1'b1);
        n = 0;
        while (match_cnt !== 16'd2 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (match_cnt !== 16'd2 || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: cnt %0d bit_valid %b, expected 2 and 1", match_cnt, bit_valid);
        end
        mon_done = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, stream.in_ready, bit_valid, match, done} !== 5'b0 || match_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_run: flags %b cnt %0d, expected 00000 and 0",
                     {busy, stream.in_ready, bit_valid, match, done}, match_cnt);
        end
        repeat (12) tick();
        checks++;
        if (mon_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done pulses %0d busy %b, expected 0 and 0", mon_done, busy);
        end
        pulse_start();
        checks++;
        if ({cfg_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rst_cfg_len_cleared: cfg_err,busy=%b, expected 10", {cfg_err, busy});
        end
    endtask

    initial begin
        test_reset();
        test_cfg_len_zero();
        test_overlap(1'b1, 3, 16'h0094);
        test_overlap(1'b0, 2, 16'h0084);
        test_back_to_back();
        test_load_stall();
        test_ignored_inputs();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
